imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined RISC-V immediate generator for the decode stage. Takes a 32-bit instruction,
//  classifies its format and sign-extends the immediate to XLEN. Replaces the
//  combinational extender: covers all I/S/B/U/J formats, flags illegal opcodes and
//  sits behind a valid/ready handshake with a 2-entry skid buffer toward execute.
// PARAMETERS
//  XLEN   32  output immediate width; legal values are 32 or 64 (other values: $error at elaboration)
//  CNT_W  16  width of the statistics counters (IMMGEN_STATS_EN only)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  flush         in   1      synchronous pipeline flush
//  in_valid      in   1      instr is valid
//  in_ready      out  1      block can accept instr this cycle
//  instr         in   32     instruction word
//  out_valid     out  1      imm/fmt/illegal are valid
//  out_ready     in   1      consumer accepts the output this cycle
//  imm           out  XLEN   sign-extended immediate
//  fmt           out  3      0=R 1=I 2=S 3=B 4=U 5=J 7=illegal
//  illegal       out  1      opcode not recognised
//  stat_total    out  CNT_W  accepted-instruction count (IMMGEN_STATS_EN only)
//  stat_illegal  out  CNT_W  accepted-illegal count (IMMGEN_STATS_EN only)
// BEHAVIOUR
//  - Decode (combinational on instr[6:0]):
//    - I: 0000011, 0010011, 1100111
//    - S: 0100011
//    - B: 1100011
//    - U: 0110111, 0010111
//    - J: 1101111
//    - R: 0110011
//    - XLEN=64 only: 0011011 is I, 0111011 is R.
//    - Any other opcode: fmt=7, illegal=1, imm=0. This includes instr[1:0]!=2'b11.
//  - Immediates, sign bit instr[31] replicated up to bit XLEN-1:
//    - I = instr[31:20]
//    - S = {instr[31:25], instr[11:7]}
//    - B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
//    - J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}
//    - U = {instr[31:12], 12'b0}, sign-extended for XLEN=64
//    - R = 0
//  - Handshake:
//    - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//    - Once raised, out_valid and the output data stay stable until the transfer completes.
//  - Buffer: main entry drives the outputs, skid entry sits behind it. State is the occupancy:
//    - EMPTY -> ONE on accept.
//    - ONE -> TWO on accept without pop.
//    - ONE -> EMPTY on pop without accept.
//    - ONE stays ONE on simultaneous accept+pop: the new entry loads main.
//    - TWO -> ONE on pop: skid moves to main.
//  - Readiness:
//    - in_ready = (state != TWO), driven from a register, no combinational path from out_ready.
//    - out_valid = (state != EMPTY).
//  - Latency: 1 cycle from accept to out_valid when EMPTY. Throughput 1/cycle while out_ready=1.
//  - flush:
//    - Next state is EMPTY. Same-cycle input is dropped and not counted.
//    - Has priority over accept and pop. Does not clear counters.
//  - Reset (async assert, sync deassert by the system):
//    - state=EMPTY, out_valid=0, in_ready=1, imm=0, fmt=0, illegal=0, counters=0.
//    - Reset mid-transfer discards all buffered entries.
// CONFIGURATION
//  IMMGEN_STATS_EN defined:
//    - stat_total increments on every accepted instr.
//    - stat_illegal increments on accepted illegal instrs.
//    - Both saturate at all-ones. Reset clears them; flush does not.
//  IMMGEN_STATS_EN undefined: stat_* ports and counters are absent. Datapath behaviour is identical.
// TESTING
//  - addi 0xFFF00093, XLEN=32, out_ready=1 -> next cycle imm=0xFFFFFFFF, fmt=1, illegal=0.
//  - lui 0x123450B7 -> imm=0x12345000, fmt=4. With XLEN=64, 0xFFFFF0B7 -> imm=0xFFFFFFFF_FFFFF000.
//  - beq 0xFE000EE3 -> imm=0xFFFFFFFC, fmt=3. jal 0x0010006F -> imm=0x00000800, fmt=5.
//  - out_ready=0, push 3 instrs back-to-back -> in_ready=0 after 2nd accept, 3rd held.
//    out_ready=1 -> outputs drain in order, then 3rd accepted.
//  - instr 0x0000007F -> illegal=1, fmt=7, imm=0, stat_illegal=1 (STATS_EN).
//    With XLEN=32, 0x0000001B is also illegal.
//  - TWO occupied, then flush, or rst_n low mid-stream -> out_valid=0 next edge (immediately for reset), in_ready=1.
//    No stale output appears afterwards.

Source files
------------

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus between fetch/decode and execute for the pipelined immediate generator.
// The producer side uses the master modport and the immediate generator uses the slave modport.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, imm, fmt, illegal
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, imm, fmt, illegal
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer toward execute.
// Optional statistics counters are enabled by defining IMMGEN_STATS_EN.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  imm_gen_pipe_if.slave      bus
`ifdef IMMGEN_STATS_EN
  ,
  output logic [CNT_W-1:0]   stat_total,
  output logic [CNT_W-1:0]   stat_illegal
`endif
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_e;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   main_imm_q, main_imm_d;
  logic [2:0]        main_fmt_q, main_fmt_d;
  logic              main_ill_q, main_ill_d;
  logic [XLEN-1:0]   skid_imm_q, skid_imm_d;
  logic [2:0]        skid_fmt_q, skid_fmt_d;
  logic              skid_ill_q, skid_ill_d;

  fmt_e              dec_fmt;
  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_ill;
  logic              accept;
  logic              pop;

  logic [31:0] w;
  assign w = bus.instr;

  // Every immediate is a sign-extended 32-bit value, so decode at 32 bits and widen once.
  always_comb begin
    dec_fmt   = FMT_ILL;
    dec_imm32 = '0;
    case (w[6:0])
      7'b0000011, 7'b0010011, 7'b1100111: dec_fmt = FMT_I;
      7'b0100011:                         dec_fmt = FMT_S;
      7'b1100011:                         dec_fmt = FMT_B;
      7'b0110111, 7'b0010111:             dec_fmt = FMT_U;
      7'b1101111:                         dec_fmt = FMT_J;
      7'b0110011:                         dec_fmt = FMT_R;
      7'b0011011: if (XLEN == 64) dec_fmt = FMT_I;
      7'b0111011: if (XLEN == 64) dec_fmt = FMT_R;
      default:                            dec_fmt = FMT_ILL;
    endcase
    case (dec_fmt)
      FMT_I:   dec_imm32 = {{20{w[31]}}, w[31:20]};
      FMT_S:   dec_imm32 = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:   dec_imm32 = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      FMT_U:   dec_imm32 = {w[31:12], 12'b0};
      FMT_J:   dec_imm32 = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: dec_imm32 = '0;
    endcase
  end

  assign dec_imm = XLEN'(dec_imm32);
  assign dec_ill = (dec_fmt == FMT_ILL);

  assign accept = bus.in_valid & in_ready_q & ~flush;
  assign pop    = out_valid_q & bus.out_ready;

  // Occupancy FSM: main always feeds the outputs, skid only fills when main is stalled.
  always_comb begin
    state_d    = state_q;
    main_imm_d = main_imm_q;
    main_fmt_d = main_fmt_q;
    main_ill_d = main_ill_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d    = ST_ONE;
            main_imm_d = dec_imm;
            main_fmt_d = dec_fmt;
            main_ill_d = dec_ill;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state_d    = ST_TWO;
            skid_imm_d = dec_imm;
            skid_fmt_d = dec_fmt;
            skid_ill_d = dec_ill;
          end else if (accept && pop) begin
            main_imm_d = dec_imm;
            main_fmt_d = dec_fmt;
            main_ill_d = dec_ill;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d    = ST_ONE;
            main_imm_d = skid_imm_q;
            main_fmt_d = skid_fmt_q;
            main_ill_d = skid_ill_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_imm_q  <= '0;
      main_fmt_q  <= '0;
      main_ill_q  <= 1'b0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= '0;
      skid_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_imm_q  <= main_imm_d;
      main_fmt_q  <= main_fmt_d;
      main_ill_q  <= main_ill_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.imm       = main_imm_q;
  assign bus.fmt       = main_fmt_q;
  assign bus.illegal   = main_ill_q;

`ifdef IMMGEN_STATS_EN
  logic [CNT_W-1:0] total_q, total_d;
  logic [CNT_W-1:0] ill_cnt_q, ill_cnt_d;

  // Saturating counters; flush is already excluded from accept.
  always_comb begin
    total_d   = total_q;
    ill_cnt_d = ill_cnt_q;
    if (accept && !(&total_q)) total_d = total_q + CNT_W'(1);
    if (accept && dec_ill && !(&ill_cnt_q)) ill_cnt_d = ill_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q   <= '0;
      ill_cnt_q <= '0;
    end else begin
      total_q   <= total_d;
      ill_cnt_q <= ill_cnt_d;
    end
  end

  assign stat_total   = total_q;
  assign stat_illegal = ill_cnt_q;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus stream
// and are checked against a queue-based reference model plus fixed vectors.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32)) if32 ();
  imm_gen_pipe_if #(.XLEN(64)) if64 ();

  assign if32.in_valid  = in_valid;
  assign if32.instr     = instr;
  assign if32.out_ready = out_ready;
  assign if64.in_valid  = in_valid;
  assign if64.instr     = instr;
  assign if64.out_ready = out_ready;

`ifdef IMMGEN_STATS_EN
  logic [3:0]  st32_total, st32_ill;
  logic [15:0] st64_total, st64_ill;
`endif

  imm_gen_pipe #(.XLEN(32), .CNT_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if32.slave)
`ifdef IMMGEN_STATS_EN
    , .stat_total(st32_total), .stat_illegal(st32_ill)
`endif
  );

  imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(if64.slave)
`ifdef IMMGEN_STATS_EN
    , .stat_total(st64_total), .stat_illegal(st64_ill)
`endif
  );

  typedef struct {
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
  } exp_t;

  typedef struct {
    logic [31:0] w;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
  } vec_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tot32_m = 0, ill32_m = 0, tot64_m = 0, ill64_m = 0;

  // Reference decode: immediates as signed integer sums of the instruction fields.
  function automatic void ref_decode(input logic [31:0] w, input int xlen,
                                     output logic [63:0] imm, output logic [2:0] fmt);
    longint v;
    longint s;
    s = longint'(w[31]);
    case (w[6:0])
      7'h03, 7'h13, 7'h67: fmt = 3'd1;
      7'h23:               fmt = 3'd2;
      7'h63:               fmt = 3'd3;
      7'h37, 7'h17:        fmt = 3'd4;
      7'h6F:               fmt = 3'd5;
      7'h33:               fmt = 3'd0;
      7'h1B:               fmt = (xlen == 64) ? 3'd1 : 3'd7;
      7'h3B:               fmt = (xlen == 64) ? 3'd0 : 3'd7;
      default:             fmt = 3'd7;
    endcase
    case (fmt)
      3'd1: v = longint'(w[30:20]) - s * 2048;
      3'd2: v = longint'(w[30:25]) * 32 + longint'(w[11:7]) - s * 2048;
      3'd3: v = longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
                + longint'(w[11:8]) * 2 - s * 4096;
      3'd4: v = longint'(w[30:12]) * 4096 - s * 64'sd2147483648;
      3'd5: v = longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
                + longint'(w[30:21]) * 2 - s * 64'sd1048576;
      default: v = 0;
    endcase
    imm = v;
  endfunction

  function automatic exp_t model_entry(input logic [31:0] w);
    exp_t e;
    logic [63:0] i32;
    ref_decode(w, 32, i32, e.fmt32);
    e.imm32 = i32[31:0];
    ref_decode(w, 64, e.imm64, e.fmt64);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs with the model, then advance the model with the inputs seen this cycle.
  task automatic checkOutput();
    exp_t e;
    bit   acc;
    if (!rst_n) begin
      chk("rst_in_ready32", if32.in_ready, 1);
      chk("rst_out_valid32", if32.out_valid, 0);
      chk("rst_in_ready64", if64.in_ready, 1);
      chk("rst_out_valid64", if64.out_valid, 0);
      return;
    end
    chk("in_ready32", if32.in_ready, q.size() < 2);
    chk("out_valid32", if32.out_valid, q.size() > 0);
    chk("in_ready64", if64.in_ready, q.size() < 2);
    chk("out_valid64", if64.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      e = q[0];
      chk("imm32", if32.imm, e.imm32);
      chk("fmt32", if32.fmt, e.fmt32);
      chk("illegal32", if32.illegal, e.fmt32 == 3'd7);
      chk("imm64", if64.imm, e.imm64);
      chk("fmt64", if64.fmt, e.fmt64);
      chk("illegal64", if64.illegal, e.fmt64 == 3'd7);
    end
`ifdef IMMGEN_STATS_EN
    chk("stat_total32", st32_total, tot32_m);
    chk("stat_illegal32", st32_ill, ill32_m);
    chk("stat_total64", st64_total, tot64_m);
    chk("stat_illegal64", st64_ill, ill64_m);
`endif
    if (flush) begin
      q.delete();
    end else begin
      acc = in_valid && (q.size() < 2);
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        e = model_entry(instr);
        q.push_back(e);
        tot32_m = (tot32_m == 15) ? 15 : tot32_m + 1;
        tot64_m = (tot64_m == 65535) ? 65535 : tot64_m + 1;
        if (e.fmt32 == 3'd7) ill32_m = (ill32_m == 15) ? 15 : ill32_m + 1;
        if (e.fmt64 == 3'd7) ill64_m = (ill64_m == 65535) ? 65535 : ill64_m + 1;
      end
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic r, input logic f);
    in_valid  = v;
    instr     = w;
    out_ready = r;
    flush     = f;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    tot32_m = 0; ill32_m = 0; tot64_m = 0; ill64_m = 0;
  endtask

  vec_t tbl[10];
  logic [6:0] ops[14];

  initial begin
    tbl[0] = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 3'd1};
    tbl[1] = '{32'h123450B7, 32'h12345000, 3'd4, 64'h00000000_12345000, 3'd4};
    tbl[2] = '{32'hFFFFF0B7, 32'hFFFFF000, 3'd4, 64'hFFFFFFFF_FFFFF000, 3'd4};
    tbl[3] = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 64'hFFFFFFFF_FFFFFFFC, 3'd3};
    tbl[4] = '{32'h0010006F, 32'h00000800, 3'd5, 64'h00000000_00000800, 3'd5};
    tbl[5] = '{32'h00A12223, 32'h00000004, 3'd2, 64'h00000000_00000004, 3'd2};
    tbl[6] = '{32'h00B50533, 32'h00000000, 3'd0, 64'h00000000_00000000, 3'd0};
    tbl[7] = '{32'h0000007F, 32'h00000000, 3'd7, 64'h00000000_00000000, 3'd7};
    tbl[8] = '{32'h0000001B, 32'h00000000, 3'd7, 64'h00000000_00000000, 3'd1};
    tbl[9] = '{32'h00000012, 32'h00000000, 3'd7, 64'h00000000_00000000, 3'd7};
    ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17,
            7'h6F, 7'h33, 7'h1B, 7'h3B, 7'h7F, 7'h12, 7'h00};

    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_out_valid32", if32.out_valid, 0);
    chk("reset_in_ready32", if32.in_ready, 1);
    chk("reset_imm32", if32.imm, 0);
    chk("reset_fmt32", if32.fmt, 0);
    chk("reset_illegal32", if32.illegal, 0);
    chk("reset_imm64", if64.imm, 0);
`ifdef IMMGEN_STATS_EN
    chk("reset_stat_total32", st32_total, 0);
    chk("reset_stat_illegal32", st32_ill, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    $display("[TB] fixed vectors");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, tbl[i].w, 1'b1, 1'b0);
      chk("vec_out_valid", if32.out_valid, 1);
      chk("vec_imm32", if32.imm, tbl[i].imm32);
      chk("vec_fmt32", if32.fmt, tbl[i].fmt32);
      chk("vec_illegal32", if32.illegal, tbl[i].fmt32 == 3'd7);
      chk("vec_imm64", if64.imm, tbl[i].imm64);
      chk("vec_fmt64", if64.fmt, tbl[i].fmt64);
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end

    $display("[TB] back-pressure sequence");
    applyStimulus(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h123450B7, 1'b0, 1'b0);
    chk("bp_in_ready_full", if32.in_ready, 0);
    applyStimulus(1'b1, 32'h0010006F, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0010006F, 1'b1, 1'b0);
    chk("bp_second_in_main", if32.imm, 32'h12345000);
    applyStimulus(1'b1, 32'h0010006F, 1'b1, 1'b0);
    chk("bp_third_in_main", if32.imm, 32'h00000800);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_drained", if32.out_valid, 0);

    $display("[TB] flush with two entries");
    applyStimulus(1'b1, 32'hFE000EE3, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000007F, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00A12223, 1'b0, 1'b1);
    chk("flush_out_valid", if32.out_valid, 0);
    chk("flush_in_ready", if32.in_ready, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000007F, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", if32.out_valid, 0);
    chk("arst_in_ready", if32.in_ready, 1);
    chk("arst_imm", if32.imm, 0);
    chk("arst_out_valid64", if64.out_valid, 0);
`ifdef IMMGEN_STATS_EN
    chk("arst_stat_total", st32_total, 0);
`endif
    model_reset();
    applyStimulus(1'b1, 32'h123450B7, 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [31:0] tmp;
      logic [6:0]  op;
      tmp = $urandom();
      op  = ops[$urandom_range(0, 13)];
      applyStimulus($urandom_range(0, 3) != 0, {tmp[31:7], op},
                    $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
